// File: rtl/serial_conv_scheduler.sv
// serial_conv_scheduler: walks every 3x3 output position, runs one loader pass per position, drains the PE, hands the result out.
// Latency: per position = loader pass + 1 + DRAIN_CYC + 1 capture + 1 write cycle (with res_ready high).
// Backpressure: holds res_valid/res_addr/res_data in WRITE until res_ready; no new loader pass starts until the handshake.
// Optional: define SERIAL_SCHED_RELU_EN to clamp negative captured results to zero.
module serial_conv_scheduler #(
   parameter int OUT_ROWS   = 3,
   parameter int OUT_COLS   = 3,
   parameter int ROW_STRIDE = 5,
   parameter int FEAT_BASE  = 9,
   parameter int ACC_W      = 16,
   parameter int DRAIN_CYC  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic             ld_en,
   output logic [7:0]       ld_baseaddr,
   input  logic             ld_done,
   input  logic [ACC_W-1:0] pe_acc,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [7:0]       res_addr,
   output logic [ACC_W-1:0] res_data
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_WRITE,
      S_DONE
   } state_t;

   localparam logic [3:0] LAST_ROW = 4'(OUT_ROWS - 1);
   localparam logic [3:0] LAST_COL = 4'(OUT_COLS - 1);

   state_t           state;
   state_t           state_nxt;
   logic [3:0]       row;
   logic [3:0]       col;
   logic [7:0]       drain_cnt;
   logic             armed;
   logic [ACC_W-1:0] res_data_q;
   logic [7:0]       base_calc;
   logic [7:0]       lin_calc;
   logic             last_pos;
   logic             start_ok;

   // Address arithmetic is 8 bits wide so the base address wraps mod 256 naturally.
   assign base_calc = 8'(FEAT_BASE) + 8'(row) * 8'(ROW_STRIDE) + 8'(col);
   assign lin_calc  = 8'(row) * 8'(OUT_COLS) + 8'(col);
   assign last_pos  = (row == LAST_ROW) && (col == LAST_COL);
   assign start_ok  = start && armed;
   assign res_data  = res_data_q;

   // Arm start acceptance one cycle after reset release so a start coinciding with release is dropped.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         armed <= 1'b0;
      end else begin
         armed <= 1'b1;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and state-decoded outputs; outputs are zero unless the state drives them.
   always_comb begin
      state_nxt   = state;
      busy        = 1'b0;
      done        = 1'b0;
      ld_en       = 1'b0;
      ld_baseaddr = 8'd0;
      res_valid   = 1'b0;
      res_addr    = 8'd0;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               state_nxt = S_LOAD;
            end
         end
         S_LOAD: begin
            busy        = 1'b1;
            ld_en       = 1'b1;
            ld_baseaddr = base_calc;
            if (ld_done) begin
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (drain_cnt == 8'd0) begin
               state_nxt = S_WRITE;
            end
         end
         S_WRITE: begin
            busy      = 1'b1;
            res_valid = 1'b1;
            res_addr  = lin_calc;
            if (res_ready) begin
               state_nxt = last_pos ? S_DONE : S_LOAD;
            end
         end
         S_DONE: begin
            done      = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Position counters, drain counter and result capture.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row        <= 4'd0;
         col        <= 4'd0;
         drain_cnt  <= 8'd0;
         res_data_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  row <= 4'd0;
                  col <= 4'd0;
               end
            end
            S_LOAD: begin
               if (ld_done) begin
                  drain_cnt <= 8'(DRAIN_CYC);
               end
            end
            S_DRAIN: begin
               if (drain_cnt == 8'd0) begin
`ifdef SERIAL_SCHED_RELU_EN
                  res_data_q <= pe_acc[ACC_W-1] ? '0 : pe_acc;
`else
                  res_data_q <= pe_acc;
`endif
               end else begin
                  drain_cnt <= drain_cnt - 8'd1;
               end
            end
            S_WRITE: begin
               if (res_ready) begin
                  if (col == LAST_COL) begin
                     col <= 4'd0;
                     row <= row + 4'd1;
                  end else begin
                     col <= col + 4'd1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_conv_scheduler.sv
// tb_serial_conv_scheduler: scoreboard bench for the 3x3 default scheduler plus a 1x1 instance.
// Loader model pulses ld_done 18 cycles after ld_en rises and returns 0x10+position derived from the base address.
// Expected results are queued per frame; a negedge monitor pops and compares on every handshake.
module tb_serial_conv_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        busy, done, ld_en, ld_done, res_valid, res_ready;
   logic [7:0]  ld_baseaddr, res_addr;
   logic [15:0] pe_acc, res_data;

   logic        start1;
   logic        busy1, done1, ld_en1, ld_done1, res_valid1, res_ready1;
   logic [7:0]  ld_baseaddr1, res_addr1;
   logic [15:0] pe_acc1, res_data1;

   logic        force_done;
   int          errors = 0;
   int          checks = 0;
   int          n_writes = 0;
   int          n_done = 0;
   logic [23:0] exp_q[$];
   logic [7:0]  base_q[$];

   int          n_pass1 = 0;
   int          n_res1 = 0;
   int          n_done1 = 0;
   logic [7:0]  base1_got;
   logic [7:0]  addr1_got;
   logic [15:0] data1_got;

   always #5 clk = ~clk;

   serial_conv_scheduler dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ld_en(ld_en), .ld_baseaddr(ld_baseaddr), .ld_done(ld_done), .pe_acc(pe_acc),
      .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data)
   );

   serial_conv_scheduler #(.OUT_ROWS(1), .OUT_COLS(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .ld_en(ld_en1), .ld_baseaddr(ld_baseaddr1), .ld_done(ld_done1), .pe_acc(pe_acc1),
      .res_valid(res_valid1), .res_ready(res_ready1), .res_addr(res_addr1), .res_data(res_data1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] model_acc(input logic [7:0] b);
      int d;
      d = int'(b) - 9;
      return 16'(16 + (d / 5) * 3 + (d % 5));
   endfunction

   function automatic logic [7:0] pos_base(input int i);
      return 8'(9 + (i / 3) * 5 + (i % 3));
   endfunction

   // Loader model for the 3x3 instance; also checks each new pass base address.
   initial begin
      int  ld_cnt;
      logic prev_en;
      logic [7:0] eb;
      ld_done = 1'b0;
      pe_acc  = 16'd0;
      ld_cnt  = 0;
      prev_en = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ld_done = force_done;
         if (ld_en && !prev_en) begin
            if (base_q.size() == 0) begin
               chk("unexpected_pass", 32'(ld_baseaddr), 32'hFFFF);
            end else begin
               eb = base_q.pop_front();
               chk("ld_baseaddr", 32'(ld_baseaddr), 32'(eb));
            end
         end
         prev_en = ld_en;
         if (!ld_en) begin
            ld_cnt = 0;
         end else begin
            ld_cnt++;
            if (ld_cnt == 18) begin
               ld_done = 1'b1;
               pe_acc  = model_acc(ld_baseaddr);
               ld_cnt  = 0;
            end
         end
      end
   end

   // Result monitor for the 3x3 instance.
   initial begin
      logic [23:0] e;
      forever begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            n_writes++;
            if (exp_q.size() == 0) begin
               chk("unexpected_result", {8'd0, res_addr, res_data}, 32'hFFFFFFFF);
            end else begin
               e = exp_q.pop_front();
               chk("res_addr", 32'(res_addr), 32'(e[23:16]));
               chk("res_data", 32'(res_data), 32'(e[15:0]));
            end
         end
         if (done) n_done++;
      end
   end

   // Loader model and observer for the 1x1 instance.
   initial begin
      int  ld_cnt;
      logic prev_en;
      ld_done1 = 1'b0;
      ld_cnt   = 0;
      prev_en  = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ld_done1 = 1'b0;
         if (ld_en1 && !prev_en) begin
            n_pass1++;
            base1_got = ld_baseaddr1;
         end
         prev_en = ld_en1;
         if (!ld_en1) begin
            ld_cnt = 0;
         end else begin
            ld_cnt++;
            if (ld_cnt == 18) begin
               ld_done1 = 1'b1;
               ld_cnt   = 0;
            end
         end
         if (res_valid1 && res_ready1) begin
            n_res1++;
            addr1_got = res_addr1;
            data1_got = res_data1;
         end
         if (done1) n_done1++;
      end
   end

   task automatic push_frame(input int npos);
      for (int i = 0; i < npos; i++) begin
         exp_q.push_back({8'(i), 16'(16 + i)});
         base_q.push_back(pos_base(i));
      end
   endtask

   task automatic run_frame();
      int w0, d0, t;
      w0 = n_writes;
      d0 = n_done;
      push_frame(9);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", 32'(done), 32'd1);
      chk("busy_in_done", 32'(busy), 32'd0);
      repeat (4) @(negedge clk);
      chk("write_count", 32'(n_writes - w0), 32'd9);
      chk("done_count", 32'(n_done - d0), 32'd1);
      chk("exp_q_empty", 32'(exp_q.size()), 32'd0);
      chk("base_q_empty", 32'(base_q.size()), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
   endtask

   task automatic run_1x1(input logic [15:0] acc, input logic [15:0] exp_data);
      int p0, r0, d0, t;
      p0 = n_pass1;
      r0 = n_res1;
      d0 = n_done1;
      pe_acc1 = acc;
      @(negedge clk);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      t = 0;
      while (!done1 && t < 500) begin
         @(negedge clk);
         t++;
      end
      chk("done1_seen", 32'(done1), 32'd1);
      repeat (3) @(negedge clk);
      chk("pass1_count", 32'(n_pass1 - p0), 32'd1);
      chk("base1", 32'(base1_got), 32'd9);
      chk("res1_count", 32'(n_res1 - r0), 32'd1);
      chk("addr1", 32'(addr1_got), 32'd0);
      chk("data1", 32'(data1_got), 32'(exp_data));
      chk("done1_count", 32'(n_done1 - d0), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      int t;
      logic [15:0] neg_exp;
      rst        = 1'b0;
      start      = 1'b0;
      start1     = 1'b0;
      res_ready  = 1'b1;
      res_ready1 = 1'b1;
      force_done = 1'b0;
      pe_acc1    = 16'd0;
      repeat (3) @(negedge clk);

      // Reset state.
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ld_en", 32'(ld_en), 32'd0);
      chk("rst_ld_baseaddr", 32'(ld_baseaddr), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_addr", 32'(res_addr), 32'd0);
      chk("rst_res_data", 32'(res_data), 32'd0);

      // Start coinciding with reset release is dropped.
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("start_at_release_busy", 32'(busy), 32'd0);
      chk("start_at_release_ld_en", 32'(ld_en), 32'd0);

      // Spurious ld_done while idle.
      force_done = 1'b1;
      @(negedge clk);
      force_done = 1'b0;
      repeat (3) @(negedge clk);
      chk("spurious_busy", 32'(busy), 32'd0);
      chk("spurious_valid", 32'(res_valid), 32'd0);
      chk("spurious_writes", 32'(n_writes), 32'd0);

      // Normal frame with an extra start pulse mid-frame.
      fork
         run_frame();
         begin
            repeat (60) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      join

      // Backpressure on position 4.
      fork
         run_frame();
         begin
            t = 0;
            do begin
               @(posedge clk);
               #1;
               t++;
            end while (!(ld_en && ld_baseaddr == 8'd15) && t < 2000);
            res_ready = 1'b0;
            t = 0;
            do begin
               @(negedge clk);
               t++;
            end while (!res_valid && t < 200);
            for (int k = 0; k < 5; k++) begin
               chk("bp_valid", 32'(res_valid), 32'd1);
               chk("bp_addr", 32'(res_addr), 32'd4);
               chk("bp_data", 32'(res_data), 32'h14);
               chk("bp_no_ld_en", 32'(ld_en), 32'd0);
               @(negedge clk);
            end
            @(posedge clk);
            #1;
            res_ready = 1'b1;
         end
      join

      // Asynchronous reset in LOAD at position 2.
      push_frame(2);
      base_q.push_back(pos_base(2));
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t = 0;
      do begin
         @(posedge clk);
         #1;
         t++;
      end while (!(ld_en && ld_baseaddr == 8'd11) && t < 2000);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_ld_en", 32'(ld_en), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_res_valid", 32'(res_valid), 32'd0);
      chk("arst_exp_q", 32'(exp_q.size()), 32'd0);
      chk("arst_base_q", 32'(base_q.size()), 32'd0);
      t = n_done;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("arst_no_done", 32'(n_done - t), 32'd0);

      // Fresh frame after reset restarts at base 9 / address 0.
      run_frame();

      // 1x1 instance: positive value, then a negative value.
      run_1x1(16'h0042, 16'h0042);
`ifdef SERIAL_SCHED_RELU_EN
      neg_exp = 16'h0000;
`else
      neg_exp = 16'hFFF0;
`endif
      run_1x1(16'hFFF0, neg_exp);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
